// File: rtl/vga_frame_capture.sv
// VGA receive-side monitor: samples sync and colour on pixel-enable strobes,
// recovers active pixel coordinates, checks line/frame timing, tracks lock
// and produces a 16-bit checksum of every good frame.
module vga_frame_capture #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        pix_en,
   input  logic        vga_hs,
   input  logic        vga_vs,
   input  logic [3:0]  vga_red,
   input  logic [3:0]  vga_green,
   input  logic [3:0]  vga_blue,
   output logic        pix_valid,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [11:0] pix_rgb,
   output logic        frame_done,
   output logic [15:0] frame_sum,
   output logic        locked,
   output logic        h_err,
   output logic        v_err
);

   localparam int H_TOTAL = H_FP + H_SYNC + H_BP + H_ACTIVE;
   localparam int V_TOTAL = V_FP + V_SYNC + V_BP + V_ACTIVE;
   localparam int HOFF    = H_SYNC + H_BP;
   localparam int VOFF    = V_SYNC + V_BP;

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_START  = 11'(HOFF);
   localparam logic [10:0] H_END    = 11'(HOFF + H_ACTIVE);
   localparam logic [9:0]  V_START  = 10'(VOFF);
   localparam logic [9:0]  V_END    = 10'(VOFF + V_ACTIVE);
   localparam logic [10:0] H_MAX    = 11'h7FF;
   localparam logic [9:0]  V_MAX    = 10'h3FF;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        hs_a_prev;
   logic        vs_a_prev;
   logic [10:0] hcnt;
   logic [9:0]  vcnt;
   logic        frame_bad;
   logic [15:0] sum_acc;

   logic        hs_a;
   logic        vs_a;
   logic        hs_edge;
   logic        vs_edge;
   logic        tracking;
   logic [10:0] h_cur;
   logic [9:0]  v_pre;
   logic [9:0]  v_cur;
   logic        h_mis;
   logic        v_mis;
   logic        bad_now;
   logic        active;
   logic        done_now;
   logic [11:0] rgb_in;

   // Decode the current sample: sync edges, indices, timing checks and next state.
   always_comb begin
      hs_a       = (vga_hs == HS_POL);
      vs_a       = (vga_vs == VS_POL);
      hs_edge    = pix_en && hs_a && !hs_a_prev;
      vs_edge    = pix_en && vs_a && !vs_a_prev;
      tracking   = (state != UNLOCKED);
      rgb_in     = {vga_red, vga_green, vga_blue};
      h_cur      = hs_edge ? 11'd0 : ((hcnt == H_MAX) ? hcnt : hcnt + 11'd1);
      v_pre      = hs_edge ? ((vcnt == V_MAX) ? vcnt : vcnt + 10'd1) : vcnt;
      v_cur      = vs_edge ? 10'd0 : v_pre;
      h_mis      = hs_edge && tracking && (hcnt != H_LAST);
      v_mis      = vs_edge && tracking && (vcnt != V_LAST);
      bad_now    = frame_bad || h_mis || v_mis;
      active     = pix_en && tracking &&
                   (h_cur >= H_START) && (h_cur < H_END) &&
                   (v_cur >= V_START) && (v_cur < V_END);
      done_now   = vs_edge && tracking && !bad_now;
      state_next = state;
      case (state)
         UNLOCKED: if (vs_edge) state_next = ACQUIRE;
         ACQUIRE:  if (vs_edge && !bad_now) state_next = LOCKED;
         LOCKED: begin
            if (h_mis) state_next = ACQUIRE;
            else if (vs_edge && bad_now) state_next = ACQUIRE;
         end
         default:  state_next = UNLOCKED;
      endcase
   end

   // Lock state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= UNLOCKED;
      else       state <= state_next;
   end

   // Counters, sticky errors, checksum and registered pixel/frame outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hs_a_prev  <= 1'b1;
         vs_a_prev  <= 1'b1;
         hcnt       <= H_MAX;
         vcnt       <= 10'd0;
         frame_bad  <= 1'b0;
         sum_acc    <= 16'd0;
         pix_valid  <= 1'b0;
         pix_x      <= 10'd0;
         pix_y      <= 10'd0;
         pix_rgb    <= 12'd0;
         frame_done <= 1'b0;
         frame_sum  <= 16'd0;
         h_err      <= 1'b0;
         v_err      <= 1'b0;
      end else begin
         pix_valid  <= active;
         frame_done <= done_now;
         if (pix_en) begin
            hs_a_prev <= hs_a;
            vs_a_prev <= vs_a;
            hcnt      <= h_cur;
            vcnt      <= v_cur;
            if (h_mis) h_err <= 1'b1;
            if (v_mis) v_err <= 1'b1;
            if (active) begin
               pix_x   <= 10'(h_cur - H_START);
               pix_y   <= v_cur - V_START;
               pix_rgb <= rgb_in;
            end
            if (done_now) frame_sum <= sum_acc;
            if (vs_edge) begin
               frame_bad <= 1'b0;
               sum_acc   <= 16'd0;
            end else begin
               if (h_mis)  frame_bad <= 1'b1;
               if (active) sum_acc   <= sum_acc + 16'(rgb_in);
            end
         end
      end
   end

   assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture: a small-timing configuration is driven with
// generated frames (clean, short line, long frame, mid-frame reset) into two
// instances, one with active-low syncs and one with active-high syncs.
// A frame-level reference model predicts pixels, checksums and lock state.
module tb_vga_frame_capture;

   localparam int H_ACTIVE = 8;
   localparam int H_FP     = 2;
   localparam int H_SYNC   = 2;
   localparam int H_BP     = 2;
   localparam int V_ACTIVE = 4;
   localparam int V_FP     = 1;
   localparam int V_SYNC   = 1;
   localparam int V_BP     = 1;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HOFF     = H_SYNC + H_BP;
   localparam int VOFF     = V_SYNC + V_BP;

   typedef struct {
      int x;
      int y;
      int rgb;
   } pix_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        pix_en;
   logic        hs_n, vs_n, hs_p, vs_p;
   logic [3:0]  red, green, blue;

   logic        pix_valid_w  [2];
   logic [9:0]  pix_x_w      [2];
   logic [9:0]  pix_y_w      [2];
   logic [11:0] pix_rgb_w    [2];
   logic        frame_done_w [2];
   logic [15:0] frame_sum_w  [2];
   logic        locked_w     [2];
   logic        h_err_w      [2];
   logic        v_err_w      [2];

   int n_cmp  = 0;
   int n_fail = 0;
   int valid_count [2];

   pix_t pix_q0 [$];
   pix_t pix_q1 [$];
   int   sum_q0 [$];
   int   sum_q1 [$];

   bit m_hs_prev, m_vs_prev, m_seen_vs, m_lock, m_bad, m_herr, m_verr;
   int m_h, m_v, m_sum, m_last_sum;

   vga_frame_capture #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) u_dut0 (
      .clk(clk), .rstn(rstn), .pix_en(pix_en),
      .vga_hs(hs_n), .vga_vs(vs_n),
      .vga_red(red), .vga_green(green), .vga_blue(blue),
      .pix_valid(pix_valid_w[0]), .pix_x(pix_x_w[0]), .pix_y(pix_y_w[0]),
      .pix_rgb(pix_rgb_w[0]), .frame_done(frame_done_w[0]),
      .frame_sum(frame_sum_w[0]), .locked(locked_w[0]),
      .h_err(h_err_w[0]), .v_err(v_err_w[0])
   );

   vga_frame_capture #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) u_dut1 (
      .clk(clk), .rstn(rstn), .pix_en(pix_en),
      .vga_hs(hs_p), .vga_vs(vs_p),
      .vga_red(red), .vga_green(green), .vga_blue(blue),
      .pix_valid(pix_valid_w[1]), .pix_x(pix_x_w[1]), .pix_y(pix_y_w[1]),
      .pix_rgb(pix_rgb_w[1]), .frame_done(frame_done_w[1]),
      .frame_sum(frame_sum_w[1]), .locked(locked_w[1]),
      .h_err(h_err_w[1]), .v_err(v_err_w[1])
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkVal(input string name, input int inst,
                           input longint actual, input longint expected);
      n_cmp++;
      if (actual != expected) begin
         n_fail++;
         $display("[TB] FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t",
                  name, inst, actual, expected, $time);
      end
   endtask

   // Put the reference model back into its post-reset condition.
   task automatic modelReset();
      m_hs_prev  = 1'b1;
      m_vs_prev  = 1'b1;
      m_seen_vs  = 1'b0;
      m_lock     = 1'b0;
      m_bad      = 1'b0;
      m_herr     = 1'b0;
      m_verr     = 1'b0;
      m_h        = 2047;
      m_v        = 0;
      m_sum      = 0;
      m_last_sum = 0;
      pix_q0.delete();
      pix_q1.delete();
      sum_q0.delete();
      sum_q1.delete();
   endtask

   // Reference behaviour for one pixel-enable sample; queues expected outputs.
   task automatic modelSample(input bit hs_on, input bit vs_on, input int rgb);
      bit   hs_edge, vs_edge, tracking;
      int   h, v_before, v;
      pix_t e;
      hs_edge  = hs_on && !m_hs_prev;
      vs_edge  = vs_on && !m_vs_prev;
      tracking = m_seen_vs;
      h        = hs_edge ? 0 : ((m_h + 1 > 2047) ? 2047 : m_h + 1);
      v_before = hs_edge ? ((m_v + 1 > 1023) ? 1023 : m_v + 1) : m_v;
      v        = vs_edge ? 0 : v_before;
      if (tracking && hs_edge && m_h != H_TOTAL - 1) begin
         m_herr = 1'b1;
         m_bad  = 1'b1;
         m_lock = 1'b0;
      end
      if (tracking && vs_edge && m_v != V_TOTAL - 1) begin
         m_verr = 1'b1;
         m_bad  = 1'b1;
      end
      if (tracking && h >= HOFF && h < HOFF + H_ACTIVE &&
          v >= VOFF && v < VOFF + V_ACTIVE) begin
         e.x   = h - HOFF;
         e.y   = v - VOFF;
         e.rgb = rgb;
         pix_q0.push_back(e);
         pix_q1.push_back(e);
         m_sum = (m_sum + rgb) % 65536;
      end
      if (vs_edge) begin
         if (tracking) begin
            if (!m_bad) begin
               sum_q0.push_back(m_sum);
               sum_q1.push_back(m_sum);
               m_last_sum = m_sum;
               m_lock     = 1'b1;
            end else begin
               m_lock = 1'b0;
            end
         end
         m_seen_vs = 1'b1;
         m_bad     = 1'b0;
         m_sum     = 0;
      end
      m_h       = h;
      m_v       = v;
      m_hs_prev = hs_on;
      m_vs_prev = vs_on;
   endtask

   // Status outputs that must track the model after every sample.
   task automatic checkOutput();
      for (int i = 0; i < 2; i++) begin
         checkVal("locked",    i, locked_w[i],    m_lock);
         checkVal("h_err",     i, h_err_w[i],     m_herr);
         checkVal("v_err",     i, v_err_w[i],     m_verr);
         checkVal("frame_sum", i, frame_sum_w[i], m_last_sum);
      end
   endtask

   // Everything must read zero while or just after reset is applied.
   task automatic checkAllZero();
      for (int i = 0; i < 2; i++) begin
         checkVal("rst_pix_valid",  i, pix_valid_w[i],  0);
         checkVal("rst_pix_x",      i, pix_x_w[i],      0);
         checkVal("rst_pix_y",      i, pix_y_w[i],      0);
         checkVal("rst_pix_rgb",    i, pix_rgb_w[i],    0);
         checkVal("rst_frame_done", i, frame_done_w[i], 0);
         checkVal("rst_frame_sum",  i, frame_sum_w[i],  0);
         checkVal("rst_locked",     i, locked_w[i],     0);
         checkVal("rst_h_err",      i, h_err_w[i],      0);
         checkVal("rst_v_err",      i, v_err_w[i],      0);
      end
   endtask

   // One pixel-enable sample followed by a random idle gap (period 4-6 clocks).
   task automatic applyStimulus(input bit hs_on, input bit vs_on, input logic [11:0] rgb);
      @(negedge clk);
      hs_n   = !hs_on;
      vs_n   = !vs_on;
      hs_p   = hs_on;
      vs_p   = vs_on;
      {red, green, blue} = rgb;
      pix_en = 1'b1;
      modelSample(hs_on, vs_on, int'(rgb));
      @(negedge clk);
      pix_en = 1'b0;
      checkOutput();
      repeat ($urandom_range(2, 4)) @(negedge clk);
   endtask

   // Generate one frame; optional short line and early stop after N samples.
   task automatic sendFrame(input int n_lines, input int short_line, input int short_len,
                            input bit pattern, input int stop_after);
      int          cnt;
      int          len;
      logic [11:0] rgb;
      cnt = 0;
      for (int v = 0; v < n_lines; v++) begin
         len = (v == short_line) ? short_len : H_TOTAL;
         for (int h = 0; h < len; h++) begin
            if (stop_after >= 0 && cnt == stop_after) return;
            rgb = 12'($urandom);
            if (pattern && h >= HOFF && h < HOFF + H_ACTIVE &&
                v >= VOFF && v < VOFF + V_ACTIVE)
               rgb = 12'((h - HOFF) + 16 * (v - VOFF));
            applyStimulus(h < H_SYNC, v < V_SYNC, rgb);
            cnt++;
         end
      end
   endtask

   // Scoreboard monitor: pops expected pixels / frame sums as the DUTs present them.
   always @(negedge clk) begin : monitor
      pix_t e;
      int   s;
      bit   have;
      if (rstn) begin
         for (int i = 0; i < 2; i++) begin
            if (pix_valid_w[i]) begin
               valid_count[i]++;
               have = 1'b0;
               if (i == 0 && pix_q0.size() > 0) begin e = pix_q0.pop_front(); have = 1'b1; end
               if (i == 1 && pix_q1.size() > 0) begin e = pix_q1.pop_front(); have = 1'b1; end
               if (!have) begin
                  checkVal("unexpected_pix_valid", i, 1, 0);
               end else begin
                  checkVal("pix_x",   i, pix_x_w[i],   e.x);
                  checkVal("pix_y",   i, pix_y_w[i],   e.y);
                  checkVal("pix_rgb", i, pix_rgb_w[i], e.rgb);
               end
            end
            if (frame_done_w[i]) begin
               have = 1'b0;
               if (i == 0 && sum_q0.size() > 0) begin s = sum_q0.pop_front(); have = 1'b1; end
               if (i == 1 && sum_q1.size() > 0) begin s = sum_q1.pop_front(); have = 1'b1; end
               if (!have) checkVal("unexpected_frame_done", i, 1, 0);
               else       checkVal("done_frame_sum", i, frame_sum_w[i], s);
            end
         end
      end
   end

   // Hard time limit so the bench can never hang.
   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Scenario sequence.
   initial begin
      valid_count[0] = 0;
      valid_count[1] = 0;
      rstn   = 1'b0;
      pix_en = 1'b0;
      hs_n = 1'b1; vs_n = 1'b1; hs_p = 1'b0; vs_p = 1'b0;
      red = 4'd0; green = 4'd0; blue = 4'd0;
      modelReset();
      repeat (3) @(negedge clk);
      checkAllZero();
      rstn = 1'b1;

      // Patterned clean frames: lock, then a good checksum of 0x0370.
      sendFrame(V_TOTAL, -1, 0, 1'b1, -1);
      sendFrame(V_TOTAL, -1, 0, 1'b1, -1);
      sendFrame(V_TOTAL, -1, 0, 1'b1, -1);
      valid_count[0] = 0;
      valid_count[1] = 0;
      sendFrame(V_TOTAL, -1, 0, 1'b1, -1);
      for (int i = 0; i < 2; i++) begin
         checkVal("locked_after_clean",  i, locked_w[i],    1);
         checkVal("pattern_frame_sum",   i, frame_sum_w[i], 16'h0370);
         checkVal("valid_count_frame",   i, valid_count[i], 32);
         checkVal("clean_h_err",         i, h_err_w[i],     0);
         checkVal("clean_v_err",         i, v_err_w[i],     0);
      end

      // Random-colour clean frame, then a frame containing a 13-sample line.
      sendFrame(V_TOTAL, -1, 0, 1'b0, -1);
      sendFrame(V_TOTAL, 3, H_TOTAL - 1, 1'b0, -1);
      for (int i = 0; i < 2; i++) begin
         checkVal("short_line_h_err",  i, h_err_w[i],  1);
         checkVal("short_line_locked", i, locked_w[i], 0);
      end
      sendFrame(V_TOTAL, -1, 0, 1'b0, -1);
      sendFrame(V_TOTAL, -1, 0, 1'b0, -1);
      sendFrame(V_TOTAL, -1, 0, 1'b0, -1);

      // Long frame of eight lines while locked.
      sendFrame(V_TOTAL + 1, -1, 0, 1'b0, -1);
      sendFrame(V_TOTAL, -1, 0, 1'b0, -1);
      for (int i = 0; i < 2; i++) begin
         checkVal("long_frame_v_err",  i, v_err_w[i],  1);
         checkVal("long_frame_locked", i, locked_w[i], 0);
      end
      sendFrame(V_TOTAL, -1, 0, 1'b0, -1);
      sendFrame(V_TOTAL, -1, 0, 1'b0, -1);

      // Reset pulse in the middle of an active line.
      sendFrame(V_TOTAL, -1, 0, 1'b0, 3 * H_TOTAL + 7);
      #2;
      rstn = 1'b0;
      #1;
      checkAllZero();
      modelReset();
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      sendFrame(V_TOTAL, -1, 0, 1'b0, -1);
      sendFrame(V_TOTAL, -1, 0, 1'b0, -1);
      for (int i = 0; i < 2; i++) begin
         checkVal("post_reset_locked",    i, locked_w[i],    0);
         checkVal("post_reset_frame_sum", i, frame_sum_w[i], 0);
      end
      sendFrame(V_TOTAL, -1, 0, 1'b0, -1);
      for (int i = 0; i < 2; i++)
         checkVal("relock_after_reset", i, locked_w[i], 1);
      sendFrame(V_TOTAL, -1, 0, 1'b0, -1);

      repeat (4) @(negedge clk);
      checkVal("pixels_left", 0, pix_q0.size(), 0);
      checkVal("pixels_left", 1, pix_q1.size(), 0);
      checkVal("sums_left",   0, sum_q0.size(), 0);
      checkVal("sums_left",   1, sum_q1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
